vga_timing_multi: RTL and testbench
===================================

Name: vga_timing_multi

Overview:
- Parametrised, two-mode successor to the fixed 1024x768 VGA timing generator.
- Produces hcount, vcount, sync and blanking on the standard VGA bus, with per-mode porch, sync-width and sync-polarity parameters.
- Mode switches happen only at frame boundaries. Adds a pixel enable (stall), frame/line start strobes and a mode-status output.
- Sits at the head of the video pipeline; every draw stage consumes its vga_out bus.

Parameters:
- CNT_W, 11, width of the h/v counters; must hold every total below.
- A_H_ACTIVE/A_H_FP/A_H_SYNC/A_H_BP, 1024/24/136/160, mode A horizontal timing in pixels (total 1344).
- A_V_ACTIVE/A_V_FP/A_V_SYNC/A_V_BP, 768/3/6/29, mode A vertical timing in lines (total 806).
- B_H_ACTIVE/B_H_FP/B_H_SYNC/B_H_BP, 800/40/128/88, mode B horizontal timing (total 1056).
- B_V_ACTIVE/B_V_FP/B_V_SYNC/B_V_BP, 600/1/4/23, mode B vertical timing (total 628).
- A_HS_POL/A_VS_POL/B_HS_POL/B_VS_POL, 1/1/1/1, sync level asserted during the sync interval (1 = active-high).

Ports:
- pclk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; when low, all state and outputs hold.
- mode_sel  in  1  requested mode (0 = A, 1 = B); sampled at frame end only.
- vga_out  out  `VGA_BUS_SIZE  VGA bus: hcount, vcount, hs, vs, hblnk, vblnk, rgb.
- frame_start  out  1  one-cycle strobe while h=0, v=0.
- line_start  out  1  one-cycle strobe while h=0.
- mode_cur  out  1  mode currently being generated.

Behaviour:
- Active mode parameters: HT = H_ACTIVE+H_FP+H_SYNC+H_BP; VT is defined likewise for vertical.
- Counters:
  - h counts 0..HT-1 and wraps to 0.
  - v increments only on the h wrap, counts 0..VT-1 and wraps to 0.
  - There is no extra count at the terminal value: mode A is exactly 1344x806, mode B exactly 1056x628.
- Decodes (a function of the current h/v and mode_cur):
  - hblnk = h >= H_ACTIVE; vblnk = v >= V_ACTIVE.
  - Horizontal sync interval: H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC. During it hs = HS_POL, otherwise hs = ~HS_POL.
  - vs is decoded the same way from v with the vertical parameters and VS_POL.
  - rgb = `BACKGROUND_COLOR.
  - frame_start = (h==0 && v==0 && en). line_start = (h==0 && en).
- Registering:
  - All bus outputs are registered, computed from next-state counters.
  - Output fields always describe the same pixel: no skew between hcount and hs/blnk. Latency from counter to output is 0 cycles.
- Reset (asynchronous, while rst=1):
  - h=0, v=0, mode_cur=0.
  - Outputs: hcount=0, vcount=0, hblnk=0, vblnk=0, hs=~A_HS_POL, vs=~A_VS_POL, frame_start=0, line_start=0.
  - First cycle after release, with en=1: outputs show h=0, v=0 and frame_start=1.
- Enable:
  - en=0 freezes h, v, mode_cur and all bus outputs.
  - frame_start and line_start drop to 0 while en=0. A held (h=0, v=0) pixel re-strobes once when en returns.
- Mode switch FSM, states RUN and PEND:
  - RUN: if mode_sel != mode_cur, go to PEND.
  - PEND: on the cycle where h=HT-1 and v=VT-1 with en=1, load mode_cur=mode_sel, wrap to h=0, v=0 and go to RUN. The next frame uses the new parameters from its first pixel.
  - If mode_sel returns to mode_cur before the frame end, return to RUN and make no change.
  - Toggles of mode_sel mid-frame never alter the current frame's timing.
- Reset mid-frame or in PEND: immediate return to mode A, h=v=0, state RUN.
- Elaboration check: generate-time error if either mode's HT or VT exceeds 2**CNT_W.

Test Plan:
- Reset release, mode_sel=0, en=1, run 2 frames:
  - period exactly 1344x806 cycles.
  - hs high for h 1048..1183 (136 clocks); vs high for v 771..776.
  - hblnk from h=1024; vblnk from v=768.
  - frame_start every 1083264 cycles.
- Set mode_sel=1 at v=100 of a mode A frame:
  - mode_cur stays 0 until after the A frame's pixel (1343,805).
  - Next frame is 1056x628: hs on h 840..967, vs on v 601..604, mode_cur=1.
- Pulse mode_sel 0->1->0 within one frame: no mode change; frame length stays 1083264.
- Hold en=0 for 50 cycles at h=500, v=10: all outputs frozen. Resume at h=501; frame length grows by exactly 50.
- Assert rst at h=700, v=300 while in mode B/PEND: outputs go to reset values immediately, without waiting for a clock edge. After release, mode A from (0,0) with frame_start=1.
- Override B_HS_POL=0 and B_VS_POL=0, run mode B: hs low exactly on h 840..967 and high elsewhere; vs likewise on v 601..604.

Source files
------------

// File: rtl/vga_timing_multi.sv
// Two-mode VGA timing generator.
// Counts h/v over the mode totals and decodes sync and blanking from those counts.
// Mode changes are deferred to frame boundaries.
// Bus outputs are registered from next-state counters, so every field describes the current pixel.
// Bus layout, MSB first:
//   hcount[10:0], vcount[10:0], vs, vblnk, hs, hblnk, rgb[11:0]
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif
`ifndef BACKGROUND_COLOR
`define BACKGROUND_COLOR 12'h000
`endif

module vga_timing_multi #(
  parameter int CNT_W      = 11,
  parameter int A_H_ACTIVE = 1024,
  parameter int A_H_FP     = 24,
  parameter int A_H_SYNC   = 136,
  parameter int A_H_BP     = 160,
  parameter int A_V_ACTIVE = 768,
  parameter int A_V_FP     = 3,
  parameter int A_V_SYNC   = 6,
  parameter int A_V_BP     = 29,
  parameter int B_H_ACTIVE = 800,
  parameter int B_H_FP     = 40,
  parameter int B_H_SYNC   = 128,
  parameter int B_H_BP     = 88,
  parameter int B_V_ACTIVE = 600,
  parameter int B_V_FP     = 1,
  parameter int B_V_SYNC   = 4,
  parameter int B_V_BP     = 23,
  parameter bit A_HS_POL   = 1'b1,
  parameter bit A_VS_POL   = 1'b1,
  parameter bit B_HS_POL   = 1'b1,
  parameter bit B_VS_POL   = 1'b1
) (
  input  logic                     pclk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     mode_sel,
  output logic [`VGA_BUS_SIZE-1:0] vga_out,
  output logic                     frame_start,
  output logic                     line_start,
  output logic                     mode_cur
);

  localparam int BUS_CW = 11;
  localparam int A_HT = A_H_ACTIVE + A_H_FP + A_H_SYNC + A_H_BP;
  localparam int A_VT = A_V_ACTIVE + A_V_FP + A_V_SYNC + A_V_BP;
  localparam int B_HT = B_H_ACTIVE + B_H_FP + B_H_SYNC + B_H_BP;
  localparam int B_VT = B_V_ACTIVE + B_V_FP + B_V_SYNC + B_V_BP;

  if (A_HT > 2**CNT_W || A_VT > 2**CNT_W) begin : g_bad_a
    $error("vga_timing_multi: mode A totals exceed the CNT_W counter range");
  end
  if (B_HT > 2**CNT_W || B_VT > 2**CNT_W) begin : g_bad_b
    $error("vga_timing_multi: mode B totals exceed the CNT_W counter range");
  end
  if (CNT_W > BUS_CW) begin : g_bad_w
    $error("vga_timing_multi: CNT_W wider than the bus count fields");
  end

  // Terminal counts and decode edges.
  // The sync-last values are inclusive, so an interval ending at the total never overflows.
  localparam logic [CNT_W-1:0] A_HT_M1 = CNT_W'(A_HT - 1);
  localparam logic [CNT_W-1:0] A_VT_M1 = CNT_W'(A_VT - 1);
  localparam logic [CNT_W-1:0] B_HT_M1 = CNT_W'(B_HT - 1);
  localparam logic [CNT_W-1:0] B_VT_M1 = CNT_W'(B_VT - 1);
  localparam logic [CNT_W-1:0] A_HACT  = CNT_W'(A_H_ACTIVE);
  localparam logic [CNT_W-1:0] A_VACT  = CNT_W'(A_V_ACTIVE);
  localparam logic [CNT_W-1:0] B_HACT  = CNT_W'(B_H_ACTIVE);
  localparam logic [CNT_W-1:0] B_VACT  = CNT_W'(B_V_ACTIVE);
  localparam logic [CNT_W-1:0] A_HSS   = CNT_W'(A_H_ACTIVE + A_H_FP);
  localparam logic [CNT_W-1:0] A_HSL   = CNT_W'(A_H_ACTIVE + A_H_FP + A_H_SYNC - 1);
  localparam logic [CNT_W-1:0] A_VSS   = CNT_W'(A_V_ACTIVE + A_V_FP);
  localparam logic [CNT_W-1:0] A_VSL   = CNT_W'(A_V_ACTIVE + A_V_FP + A_V_SYNC - 1);
  localparam logic [CNT_W-1:0] B_HSS   = CNT_W'(B_H_ACTIVE + B_H_FP);
  localparam logic [CNT_W-1:0] B_HSL   = CNT_W'(B_H_ACTIVE + B_H_FP + B_H_SYNC - 1);
  localparam logic [CNT_W-1:0] B_VSS   = CNT_W'(B_V_ACTIVE + B_V_FP);
  localparam logic [CNT_W-1:0] B_VSL   = CNT_W'(B_V_ACTIVE + B_V_FP + B_V_SYNC - 1);

  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_e;

  state_e           st_q, st_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic             hs_q, hs_d, vs_q, vs_d, hb_q, hb_d, vb_q, vb_d;
  logic             org_q, org_d, ls_q, ls_d;

  logic [CNT_W-1:0] ht_m1, vt_m1;
  logic             h_end, f_end;
  logic [CNT_W-1:0] n_hact, n_vact, n_hss, n_hsl, n_vss, n_vsl;
  logic             n_hpol, n_vpol;

  // Next-state counters and the frame-boundary mode switch FSM.
  always_comb begin
    ht_m1  = mode_q ? B_HT_M1 : A_HT_M1;
    vt_m1  = mode_q ? B_VT_M1 : A_VT_M1;
    h_end  = (h_q == ht_m1);
    f_end  = h_end && (v_q == vt_m1);
    h_d    = h_q;
    v_d    = v_q;
    mode_d = mode_q;
    st_d   = st_q;
    if (en) begin
      h_d = h_end ? '0 : h_q + CNT_W'(1);
      if (h_end) v_d = (v_q == vt_m1) ? '0 : v_q + CNT_W'(1);
      unique case (st_q)
        RUN:  if (mode_sel != mode_q) st_d = PEND;
        PEND: begin
          if (f_end) begin
            mode_d = mode_sel;
            st_d   = RUN;
          end else if (mode_sel == mode_q) begin
            st_d   = RUN;
          end
        end
        default: st_d = RUN;
      endcase
    end
  end

  // Decode sync/blank for the pixel the counters move to, using that pixel's mode.
  always_comb begin
    n_hact = mode_d ? B_HACT : A_HACT;
    n_vact = mode_d ? B_VACT : A_VACT;
    n_hss  = mode_d ? B_HSS  : A_HSS;
    n_hsl  = mode_d ? B_HSL  : A_HSL;
    n_vss  = mode_d ? B_VSS  : A_VSS;
    n_vsl  = mode_d ? B_VSL  : A_VSL;
    n_hpol = mode_d ? B_HS_POL : A_HS_POL;
    n_vpol = mode_d ? B_VS_POL : A_VS_POL;
    hb_d   = (h_d >= n_hact);
    vb_d   = (v_d >= n_vact);
    hs_d   = (h_d >= n_hss && h_d <= n_hsl) ? n_hpol : ~n_hpol;
    vs_d   = (v_d >= n_vss && v_d <= n_vsl) ? n_vpol : ~n_vpol;
    org_d  = (h_d == '0) && (v_d == '0);
    ls_d   = (h_d == '0);
  end

  // State and registered outputs.
  // With en low every next-state term equals its current value, so everything holds.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      st_q   <= RUN;
      mode_q <= 1'b0;
      h_q    <= '0;
      v_q    <= '0;
      hb_q   <= 1'b0;
      vb_q   <= 1'b0;
      hs_q   <= ~A_HS_POL;
      vs_q   <= ~A_VS_POL;
      org_q  <= 1'b1;
      ls_q   <= 1'b1;
    end else begin
      st_q   <= st_d;
      mode_q <= mode_d;
      h_q    <= h_d;
      v_q    <= v_d;
      hb_q   <= hb_d;
      vb_q   <= vb_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      org_q  <= org_d;
      ls_q   <= ls_d;
    end
  end

  // Strobes are gated by en so a held origin pixel fires once when counting resumes.
  // They are gated by rst so they read 0 during reset.
  assign frame_start = org_q & en & ~rst;
  assign line_start  = ls_q & en & ~rst;
  assign mode_cur    = mode_q;
  assign vga_out     = {BUS_CW'(h_q), BUS_CW'(v_q), vs_q, vb_q, hs_q, hb_q, `BACKGROUND_COLOR};

endmodule

// File: tb/tb_vga_timing_multi.sv
// Directed bench for vga_timing_multi.
// Uses shrunken timings, with mode B running inverted sync polarity.
// A reference model pushes the expected output of every cycle into a scoreboard.
// The expected value is popped and compared against the DUT mid-cycle.
module tb_vga_timing_multi;

  localparam int AHA = 16, AHF = 2, AHS = 3, AHB = 4;
  localparam int AVA = 10, AVF = 1, AVS = 2, AVB = 3;
  localparam int BHA = 12, BHF = 1, BHS = 2, BHB = 3;
  localparam int BVA = 8,  BVF = 1, BVS = 1, BVB = 2;
  localparam bit AHP = 1'b1, AVP = 1'b1, BHP = 1'b0, BVP = 1'b0;
  localparam int AHT = 25, AVT = 16, BHT = 18, BVT = 12;
  localparam logic [11:0] BG = 12'h000;

  logic        pclk, rst, en, mode_sel;
  logic [37:0] vga_out;
  logic        frame_start, line_start, mode_cur;

  vga_timing_multi #(
    .CNT_W(11),
    .A_H_ACTIVE(AHA), .A_H_FP(AHF), .A_H_SYNC(AHS), .A_H_BP(AHB),
    .A_V_ACTIVE(AVA), .A_V_FP(AVF), .A_V_SYNC(AVS), .A_V_BP(AVB),
    .B_H_ACTIVE(BHA), .B_H_FP(BHF), .B_H_SYNC(BHS), .B_H_BP(BHB),
    .B_V_ACTIVE(BVA), .B_V_FP(BVF), .B_V_SYNC(BVS), .B_V_BP(BVB),
    .A_HS_POL(AHP), .A_VS_POL(AVP), .B_HS_POL(BHP), .B_VS_POL(BVP)
  ) dut (
    .pclk(pclk), .rst(rst), .en(en), .mode_sel(mode_sel),
    .vga_out(vga_out), .frame_start(frame_start),
    .line_start(line_start), .mode_cur(mode_cur)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [37:0] bus;
    logic        fs;
    logic        ls;
    logic        mode;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;
  int   mh, mv, cyc, last_fs, fs_period;
  bit   mmode, mpend;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] mbus(input int h, input int v, input bit m);
    int ha, hf, hw, va, vf, vw;
    bit hp, vp;
    logic hs, vs;
    if (m) begin ha = BHA; hf = BHF; hw = BHS; va = BVA; vf = BVF; vw = BVS; hp = BHP; vp = BVP; end
    else   begin ha = AHA; hf = AHF; hw = AHS; va = AVA; vf = AVF; vw = AVS; hp = AHP; vp = AVP; end
    hs = (h >= ha + hf && h < ha + hf + hw) ? hp : !hp;
    vs = (v >= va + vf && v < va + vf + vw) ? vp : !vp;
    return {11'(h), 11'(v), vs, logic'(v >= va), hs, logic'(h >= ha), BG};
  endfunction

  task automatic mreset();
    mh = 0; mv = 0; mmode = 1'b0; mpend = 1'b0;
  endtask

  task automatic madv(input logic e, input logic s);
    int ht, vt;
    bit fe;
    ht = mmode ? BHT : AHT;
    vt = mmode ? BVT : AVT;
    fe = (mh == ht - 1) && (mv == vt - 1);
    if (e) begin
      if (mh == ht - 1) begin mh = 0; mv = (mv == vt - 1) ? 0 : mv + 1; end
      else mh++;
      if (!mpend) mpend = (s != mmode);
      else if (fe) begin mmode = s; mpend = 1'b0; end
      else if (s == mmode) mpend = 1'b0;
    end
  endtask

  // One pixel clock: drive inputs and queue the expected output.
  // Check mid-cycle, then advance the model on the clock edge.
  task automatic step(input logic e, input logic s);
    exp_t x;
    en = e; mode_sel = s;
    x.bus  = mbus(mh, mv, mmode);
    x.fs   = (mh == 0 && mv == 0 && e);
    x.ls   = (mh == 0 && e);
    x.mode = mmode;
    sb.push_back(x);
    #1;
    x = sb.pop_front();
    chk("pixel", {23'd0, vga_out, frame_start, line_start, mode_cur}, {23'd0, x});
    if (frame_start) begin fs_period = cyc - last_fs; last_fs = cyc; end
    @(posedge pclk);
    madv(e, s);
    cyc++;
    @(negedge pclk);
  endtask

  task automatic run(input int n, input logic e, input logic s);
    for (int i = 0; i < n; i++) step(e, s);
  endtask

  task automatic run_to(input int h, input int v, input logic s);
    int n;
    n = 0;
    while (!(mh == h && mv == v)) begin
      step(1'b1, s);
      n++;
      if (n > 2000) begin
        errors++;
        $error("FAIL run_to(%0d,%0d) not reached within bound", h, v);
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; mode_sel = 1'b0;
    cyc = 0; last_fs = 0; fs_period = 0;
    #1 rst = 1'b1;
    #1;
    chk("reset_async", {23'd0, vga_out, frame_start, line_start, mode_cur},
        {23'd0, 11'd0, 11'd0, !AVP, 1'b0, !AHP, 1'b0, BG, 1'b0, 1'b0, 1'b0});
    @(negedge pclk);
    rst = 1'b0;
    mreset();

    // Two mode A frames from reset.
    run(2 * AHT * AVT + 1, 1'b1, 1'b0);
    chk("period_A", fs_period, AHT * AVT);

    // Request mode B mid-frame; the switch lands after the last A pixel.
    run_to(5, 3, 1'b0);
    run_to(AHT - 1, AVT - 1, 1'b1);
    chk("mode_before_end", mode_cur, 1'b0);
    step(1'b1, 1'b1);
    chk("mode_after_end", mode_cur, 1'b1);
    run(2 * BHT * BVT + 1, 1'b1, 1'b1);
    chk("period_B", fs_period, BHT * BVT);

    // Back to mode A.
    run_to(BHT - 1, BVT - 1, 1'b0);
    step(1'b1, 1'b0);
    chk("mode_back_A", mode_cur, 1'b0);
    run(AHT * AVT + 1, 1'b1, 1'b0);
    chk("period_A2", fs_period, AHT * AVT);

    // mode_sel pulse inside one frame: no switch, no change in length.
    run_to(3, 4, 1'b0);
    run(3, 1'b1, 1'b1);
    run_to(0, 0, 1'b0);
    step(1'b1, 1'b0);
    chk("pulse_period", fs_period, AHT * AVT);
    chk("pulse_mode", mode_cur, 1'b0);

    // 50-cycle stall mid-frame stretches the frame by 50.
    run_to(10, 5, 1'b0);
    run(50, 1'b0, 1'b0);
    run_to(0, 0, 1'b0);
    step(1'b1, 1'b0);
    chk("stall_period", fs_period, AHT * AVT + 50);

    // Stall on the origin pixel: a single strobe when counting resumes.
    run_to(0, 0, 1'b0);
    run(3, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("origin_hold_period", fs_period, AHT * AVT + 3);

    // Enter mode B, then request A (PEND) and reset mid-frame.
    run_to(AHT - 1, AVT - 1, 1'b1);
    step(1'b1, 1'b1);
    run_to(5, 4, 1'b1);
    step(1'b1, 1'b0);
    chk("mode_B_pre_rst", mode_cur, 1'b1);
    rst = 1'b1;
    #1;
    chk("reset_midframe", {23'd0, vga_out, frame_start, line_start, mode_cur},
        {23'd0, 11'd0, 11'd0, !AVP, 1'b0, !AHP, 1'b0, BG, 1'b0, 1'b0, 1'b0});
    @(posedge pclk);
    @(negedge pclk);
    rst = 1'b0;
    mreset();
    run(AHT * AVT + 1, 1'b1, 1'b0);
    chk("period_after_rst", fs_period, AHT * AVT);
    chk("mode_after_rst", mode_cur, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
